// File: rtl/serial_bit_source.sv
// Parallel-to-serial front end: a holding register accepts words over valid/ready
// and feeds a shift register that emits one registered bit per bit_en tick.
module serial_bit_source #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             bit_out_q;
  logic             bit_valid_q;
  logic             frame_start_q;

  logic [WIDTH-1:0] sh_d;
  logic             next_bit_d;
  logic             accept;

  always_comb begin
    sh_d       = '0;
    next_bit_d = 1'b0;
    if (MSB_FIRST) begin
      next_bit_d = sh_q[WIDTH-1];
      sh_d       = {sh_q[WIDTH-2:0], 1'b0};
    end else begin
      next_bit_d = sh_q[0];
      sh_d       = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  assign accept      = load_valid && !hold_full_q;
  assign load_ready  = !hold_full_q;
  assign busy        = (state_q == SHIFT) || hold_full_q;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_start = frame_start_q;

  // Accept only fires with hold empty, so it never collides with a hold->sh transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      sh_q          <= '0;
      cnt_q         <= '0;
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      bit_out_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;

      if (accept) begin
        hold_q      <= load_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            sh_q        <= hold_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            bit_out_q     <= next_bit_d;
            bit_valid_q   <= 1'b1;
            frame_start_q <= (cnt_q == '0);
            sh_q          <= sh_d;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              if (hold_full_q) begin
                sh_q        <= hold_q;
                cnt_q       <= '0;
                hold_full_q <= 1'b0;
              end else begin
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial front end for the sequence detector path. It accepts WIDTH-bit words over a valid/ready handshake, double-buffers them, and shifts them out one bit per enabled cycle on a registered single-bit stream. That stream drives the detector's `din`. Idle cycles emit 0, so the detector sees no spurious 1s between words.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `load_data`  in  WIDTH  word to serialize.
- `load_valid`  in  1  `load_data` is valid.
- `load_ready`  out  1  holding buffer is empty; a word is accepted on an edge where `load_valid` and `load_ready` are both 1.
- `bit_en`  in  1  shift enable (bit-rate tick); 1 = emit one bit this edge.
- `bit_out`  out  1  serial bit, registered; 0 when `bit_valid` = 0.
- `bit_valid`  out  1  registered; high for exactly one cycle per emitted bit.
- `frame_start`  out  1  registered; high together with the first bit of each word.
- `busy`  out  1  shifter active or holding buffer full.

## Operation
- Storage:
  - holding register `hold` with flag `hold_full`;
  - shift register `sh` with flag `act` and bit counter `cnt` (0..WIDTH-1).
- `load_ready` = !`hold_full`, combinational from a register.
- `busy` = `act` | `hold_full`.
- Accept: at an edge with `load_valid` & `load_ready`, `hold` <= `load_data` and `hold_full` <= 1.
  - Accepted words always enter `hold`, never `sh` directly.
- Shifter states:
  - IDLE (`act` = 0):
    - if `hold_full`, the edge loads `sh` <= `hold`, clears `cnt` and `hold_full`, and sets `act`, regardless of `bit_en`;
    - no bit is emitted on that edge.
  - SHIFT (`act` = 1), edge with `bit_en` = 1:
    - `bit_out` <= next bit (`sh[WIDTH-1]` if MSB_FIRST, else `sh[0]`), `bit_valid` <= 1, `frame_start` <= (`cnt` == 0);
    - shift `sh` one position toward the output end; `cnt` <= `cnt`+1.
  - SHIFT, edge with `bit_en` = 1 and `cnt` == WIDTH-1 (last bit):
    - if `hold_full`: reload `sh` from `hold`, `cnt` <= 0, `hold_full` <= 0, stay in SHIFT;
    - otherwise: `act` <= 0 (IDLE).
  - SHIFT, edge with `bit_en` = 0: `sh`, `cnt` and `act` hold; `bit_valid` <= 0, `bit_out` <= 0, `frame_start` <= 0.
- Any edge that emits no bit drives `bit_valid`, `bit_out` and `frame_start` to 0.
- Simultaneous events:
  - A transfer `hold`->`sh` and a new accept cannot occur on the same edge, because `load_ready` was 0 while `hold_full` was set.
  - The next accept happens on the following edge. For WIDTH >= 2 this still sustains gap-free streaming.
- Reset (asynchronous, any time):
  - `act` = 0, `hold_full` = 0, `cnt` = 0, `sh` = 0, `hold` = 0;
  - `bit_out` = 0, `bit_valid` = 0, `frame_start` = 0;
  - `load_ready` = 1, `busy` = 0.
  - A word in flight or in `hold` is discarded; no partial bits are emitted after reset releases.

## Timing
- Latency from an idle block, with `bit_en` held at 1:
  - word accepted at edge T;
  - transferred to `sh` at edge T+1;
  - first bit visible after edge T+2, with `bit_valid` = `frame_start` = 1.
- Throughput: one bit per enabled edge.
  - If the next word is in `hold` before the last bit's edge, its first bit follows on the very next enabled edge, with zero bubble.
- `load_ready` falls the cycle after an accept.
  - It rises the cycle after the transfer edge, which is T+2 for an idle block.
- `bit_en` low stalls the shifter only. Accept and IDLE-state transfer proceed regardless of `bit_en`.
- All outputs are registered except `load_ready` and `busy`, which decode registered flags directly.

## Test plan
- Reset, then a single word, WIDTH=8, MSB_FIRST=1, `load_data` = 8'hD0, `bit_en` = 1:
  - `bit_out` = 1,1,0,1,0,0,0,0 on 8 consecutive `bit_valid` cycles starting at edge T+2;
  - `frame_start` high only on the first bit;
  - `busy` drops after the last bit;
  - detector downstream pulses `dout` once.
- Back-to-back: present 8'hD0 then 8'h3C with `load_valid` held at 1:
  - 16 contiguous `bit_valid` cycles: 11010000 00111100;
  - `frame_start` on bits 1 and 9;
  - second word accepted while the first is shifting.
- Backpressure: present three words with `load_valid` held at 1:
  - `load_ready` = 0 while `hold` is full;
  - the third word is accepted only after the second moves to `sh`;
  - all 24 bits appear in order with no loss or duplication.
- `bit_en` stall: assert `bit_en` = 1 for 3 cycles, 0 for 5, then 1:
  - 3 bits emitted, then `bit_valid` = `bit_out` = 0 for 5 cycles;
  - the remaining 5 bits resume without skip.
- MSB_FIRST=0, `load_data` = 8'h0B:
  - `bit_out` = 1,1,0,1,0,0,0,0.
- Reset asserted after the 4th bit of 8'hFF with a second word in `hold`:
  - all outputs immediately 0, `load_ready` = 1;
  - after release, no further bits until a new word is accepted.
